// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one sync-read code ROM between J1 instruction fetch (priority) and a Wishbone classic read port with bounded starvation
// clock/reset: rising-edge clock, synchronous active-high reset
// fetch_*: J1 fetch port (req/addr in, ready/valid/data out)
// wb_*: Wishbone classic slave (reads only; writes answered with a one-cycle err)
// rom_*: ROM macro port (address/cen out, q in, 1-cycle read latency)
module rom_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_cen,
  input  logic [DATA_WIDTH-1:0] rom_q
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WB_RD, WB_DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            wb_err_q, wb_err_d;
  logic            wb_sample, wb_pend, wb_wr, wb_win, fetch_gnt;
  always_comb begin
    // the cycle carrying err acts as a turnaround so a held write strobe is not re-sampled
    wb_sample     = (state_q == IDLE) & ~wb_err_q;
    wb_pend       = wb_sample & wb_cyc & wb_stb & ~wb_we;
    wb_wr         = wb_sample & wb_cyc & wb_stb & wb_we;
    wb_win        = wb_pend & (~fetch_req | (wait_cnt_q == CW'(MAX_WAIT)));
    fetch_gnt     = fetch_req & ~wb_win & (state_q != WB_RD);
    state_d       = wb_win ? WB_RD : ((state_q == WB_RD) & wb_cyc) ? WB_DONE : IDLE;
    // a pending read that loses can only be losing below MAX_WAIT, so no explicit saturation
    wait_cnt_d    = (wb_pend & ~wb_win) ? wait_cnt_q + CW'(1) : '0;
    fetch_valid_d = fetch_gnt;
    wb_err_d      = wb_wr;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      fetch_valid_q <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      wb_err_q      <= wb_err_d;
    end
  end
  assign fetch_ready = fetch_gnt;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = rom_q;
  assign rom_cen     = wb_win | fetch_gnt;
  assign rom_address = wb_win ? wb_adr : fetch_addr;
  assign wb_ack      = (state_q == WB_RD) & wb_cyc;
  assign wb_dat_o    = wb_ack ? rom_q : '0;
  assign wb_err      = wb_err_q;
endmodule
